// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes on both sides.
// Stage 1 registers the preprocessed operands (zx/nx, zy/ny applied) plus f/no.
// Stage 2 registers the final result together with the zr/ng flags.
// Optional feature: define HACK_ALU_OVF_EN to add registered carry/ovf outputs.
module hack_alu_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
`ifdef HACK_ALU_OVF_EN
   output logic             ng,
   output logic             carry,
   output logic             ovf
`else
   output logic             ng
`endif
);

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_x_q;
   logic [WIDTH-1:0] s1_y_q;
   logic             s1_f_q;
   logic             s1_no_q;

   logic             s2_free;
   logic             s1_adv;
   logic             in_xfer;

   logic [WIDTH-1:0] x_pre;
   logic [WIDTH-1:0] y_pre;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] res;

   // Handshake control: stage 2 frees up when empty or being drained this cycle.
   always_comb begin
      s2_free  = !out_valid || out_ready;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s2_free;
      in_xfer  = in_valid && in_ready;
   end

   // Operand preprocessing: zero first, then invert, so zx&nx yields all ones.
   always_comb begin
      x_pre = zx ? '0 : x;
      x_pre = nx ? ~x_pre : x_pre;
      y_pre = zy ? '0 : y;
      y_pre = ny ? ~y_pre : y_pre;
   end

`ifdef HACK_ALU_OVF_EN
   logic [WIDTH:0] sum_ext;
   logic           carry_d;
   logic           ovf_d;

   // Wide add exposes the carry; overflow when same-sign operands give a different-sign sum.
   always_comb begin
      sum_ext = {1'b0, s1_x_q} + {1'b0, s1_y_q};
      sum     = sum_ext[WIDTH-1:0];
      carry_d = s1_f_q && sum_ext[WIDTH];
      ovf_d   = s1_f_q && (s1_x_q[WIDTH-1] == s1_y_q[WIDTH-1])
                       && (sum_ext[WIDTH-1] != s1_x_q[WIDTH-1]);
   end
`else
   // Plain modular add of the preprocessed operands.
   always_comb begin
      sum = s1_x_q + s1_y_q;
   end
`endif

   // Function select and output inversion on the stage-1 contents.
   always_comb begin
      r   = s1_f_q ? sum : (s1_x_q & s1_y_q);
      res = s1_no_q ? ~r : r;
   end

   // Stage 1: load on input transfer, empty when advancing without a refill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_f_q     <= 1'b0;
         s1_no_q    <= 1'b0;
      end else begin
         if (in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_x_q     <= x_pre;
            s1_y_q     <= y_pre;
            s1_f_q     <= f;
            s1_no_q    <= no;
         end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   // Stage 2: result and flags update together; held stable while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
`ifdef HACK_ALU_OVF_EN
         carry     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         if (s1_adv) begin
            out_valid <= 1'b1;
            out       <= res;
            zr        <= (res == '0);
            ng        <= res[WIDTH-1];
`ifdef HACK_ALU_OVF_EN
            carry     <= carry_d;
            ovf       <= ovf_d;
`endif
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Scoreboard bench for hack_alu_pipe (WIDTH=16); covers HACK_ALU_OVF_EN when defined.
module tb_hack_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic        zx, nx, zy, ny, f, no;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic        zr;
   logic        ng;
`ifdef HACK_ALU_OVF_EN
   logic        carry;
   logic        ovf;
`endif

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [15:0] o;
      logic        zr;
      logic        ng;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   hack_alu_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .zx        (zx),
      .nx        (nx),
      .zy        (zy),
      .ny        (ny),
      .f         (f),
      .no        (no),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zr        (zr),
`ifdef HACK_ALU_OVF_EN
      .ng        (ng),
      .carry     (carry),
      .ovf       (ovf)
`else
      .ng        (ng)
`endif
   );

   always #5 clk = ~clk;

   // Reference model using integer arithmetic; c = {zx,nx,zy,ny,f,no}.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [5:0] c);
      exp_t        e;
      logic [15:0] xp;
      logic [15:0] yp;
      logic [15:0] rr;
      int unsigned usum;
      int          ssum;
      xp = c[5] ? 16'h0000 : a;
      if (c[4]) xp = ~xp;
      yp = c[3] ? 16'h0000 : b;
      if (c[2]) yp = ~yp;
      usum = {16'd0, xp} + {16'd0, yp};
      ssum = int'($signed(xp)) + int'($signed(yp));
      if (c[1]) begin
         rr  = usum[15:0];
         e.c = (usum > 32'd65535);
         e.v = (ssum > 32767) || (ssum < -32768);
      end else begin
         rr  = xp & yp;
         e.c = 1'b0;
         e.v = 1'b0;
      end
      if (c[0]) rr = ~rr;
      e.o  = rr;
      e.zr = (rr == 16'h0000);
      e.ng = rr[15];
      return e;
   endfunction

   // Output monitor: every output transfer pops and checks the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got out=%h with no op outstanding", out);
         end else begin
            mon_e = sb.pop_front();
`ifdef HACK_ALU_OVF_EN
            if ({out, zr, ng, carry, ovf} !== {mon_e.o, mon_e.zr, mon_e.ng, mon_e.c, mon_e.v})
               $display("FAIL sb_result: got out=%h zr=%b ng=%b c=%b v=%b, want %h %b %b %b %b",
                        out, zr, ng, carry, ovf, mon_e.o, mon_e.zr, mon_e.ng, mon_e.c, mon_e.v);
`else
            if ({out, zr, ng} !== {mon_e.o, mon_e.zr, mon_e.ng})
               $display("FAIL sb_result: got out=%h zr=%b ng=%b, want %h %b %b",
                        out, zr, ng, mon_e.o, mon_e.zr, mon_e.ng);
`endif
            else passed++;
         end
      end
   end

   // Present one op and hold it until accepted; returns 1ns after the accept edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
      logic rdy;
      int   n;
      x        = a;
      y        = b;
      {zx, nx, zy, ny, f, no} = c;
      in_valid = 1'b1;
      n        = 0;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         if (rdy) sb.push_back(model(a, b, c));
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 200) begin
            checks++;
            $display("FAIL issue_timeout: in_ready stayed 0, want 1 within 200 cycles");
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      x = '0; y = '0;
      {zx, nx, zy, ny, f, no} = 6'b000000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, zr, ng, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_state: got ov=%b out=%h zr=%b ng=%b ir=%b, want 0 0000 0 0 1",
                  out_valid, out, zr, ng, in_ready);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_add;
      out_ready = 1'b1;
      issue(16'd5, 16'd3, 6'b000010);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL add_latency_early: got ov=%b, want 0", out_valid);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, zr, ng} !== {1'b1, 16'h0008, 1'b0, 1'b0})
         $display("FAIL add_result: got ov=%b out=%h zr=%b ng=%b, want 1 0008 0 0",
                  out_valid, out, zr, ng);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_sub;
      out_ready = 1'b1;
      issue(16'd3, 16'd5, 6'b010011);
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, zr, ng} !== {1'b1, 16'hFFFE, 1'b0, 1'b1})
         $display("FAIL sub_result: got ov=%b out=%h zr=%b ng=%b, want 1 fffe 0 1",
                  out_valid, out, zr, ng);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      issue(16'($urandom), 16'($urandom), 6'b111010);
      issue(16'($urandom), 16'($urandom), 6'b101010);
      checks++;
      if ({out_valid, out, ng} !== {1'b1, 16'hFFFF, 1'b1})
         $display("FAIL b2b_ones: got ov=%b out=%h ng=%b, want 1 ffff 1", out_valid, out, ng);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, zr, ng} !== {1'b1, 16'h0000, 1'b1, 1'b0})
         $display("FAIL b2b_zero: got ov=%b out=%h zr=%b ng=%b, want 1 0000 1 0",
                  out_valid, out, zr, ng);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      issue(16'd1, 16'd1, 6'b000010);
      issue(16'd2, 16'd2, 6'b000010);
      checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_full: got in_ready=%b, want 0", in_ready);
      else passed++;
      fork
         issue(16'd3, 16'd3, 6'b000010);
         begin
            repeat (4) begin
               @(posedge clk);
               #1;
               checks++;
               if ({out_valid, out, in_ready} !== {1'b1, 16'h0002, 1'b0})
                  $display("FAIL bp_hold: got ov=%b out=%h ir=%b, want 1 0002 0",
                           out_valid, out, in_ready);
               else passed++;
            end
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) $display("FAIL bp_drain: got %0d pending, want 0", sb.size());
      else passed++;
   endtask

   task automatic test_reset_midflight;
      out_ready = 1'b0;
      issue(16'd7, 16'd9, 6'b000010);
      issue(16'd4, 16'd4, 6'b000010);
      checks++;
      if (out_valid !== 1'b1) $display("FAIL rmf_pre: got ov=%b, want 1", out_valid);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out, zr, ng} !== {1'b0, 16'h0000, 1'b0, 1'b0})
         $display("FAIL rmf_async: got ov=%b out=%h zr=%b ng=%b, want 0 0000 0 0",
                  out_valid, out, zr, ng);
      else passed++;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL rmf_ready: got in_ready=%b, want 1", in_ready);
      else passed++;
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) $display("FAIL rmf_stale: got ov=%b, want 0", out_valid);
         else passed++;
      end
   endtask

`ifdef HACK_ALU_OVF_EN
   task automatic test_ovf;
      out_ready = 1'b1;
      issue(16'h7FFF, 16'h0001, 6'b000010);
      @(posedge clk);
      #1;
      checks++;
      if ({out, ovf, carry, ng} !== {16'h8000, 1'b1, 1'b0, 1'b1})
         $display("FAIL ovf_pos: got out=%h v=%b c=%b ng=%b, want 8000 1 0 1",
                  out, ovf, carry, ng);
      else passed++;
      issue(16'hFFFF, 16'h0001, 6'b000010);
      @(posedge clk);
      #1;
      checks++;
      if ({out, carry, ovf, zr} !== {16'h0000, 1'b1, 1'b0, 1'b1})
         $display("FAIL ovf_carry: got out=%h c=%b v=%b zr=%b, want 0000 1 0 1",
                  out, carry, ovf, zr);
      else passed++;
      issue(16'hFFFF, 16'h0001, 6'b000000);
      @(posedge clk);
      #1;
      checks++;
      if ({carry, ovf} !== 2'b00)
         $display("FAIL ovf_and: got c=%b v=%b, want 0 0", carry, ovf);
      else passed++;
      issue(16'h8000, 16'h8000, 6'b000011);
      @(posedge clk);
      #1;
      checks++;
      if ({out, carry, ovf} !== {16'hFFFF, 1'b1, 1'b1})
         $display("FAIL ovf_no: got out=%h c=%b v=%b, want ffff 1 1", out, carry, ovf);
      else passed++;
      @(posedge clk);
      #1;
   endtask
`endif

   task automatic test_random;
      fork
         begin
            for (int i = 0; i < 40; i++)
               issue(16'($urandom), 16'($urandom), 6'($urandom));
         end
         begin
            repeat (90) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb.size() != 0) $display("FAIL rand_drain: got %0d pending, want 0", sb.size());
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
`ifdef HACK_ALU_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
